// File: rtl/pe4_pkg.sv
// Shared constants and types for the pe4 coefficient-bank read path.
package pe4_pkg;

  localparam int PE4_DW        = 12;
  localparam int PE4_AW        = 6;
  localparam int RD_FIFO_DEPTH = 3;
  localparam int RD_FIFO_CW    = $clog2(RD_FIFO_DEPTH + 1);
  localparam int RD_FIFO_PW    = $clog2(RD_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_e;

endpackage

// File: rtl/rd_skid_fifo.sv
// Small synchronous FIFO that catches BRAM read data while the stream
// consumer applies backpressure; head entry is visible without a pop.
module rd_skid_fifo
  import pe4_pkg::*;
#(
  parameter int DW = PE4_DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DW-1:0]         push_data,
  input  logic                  pop,
  output logic [RD_FIFO_CW-1:0] count,
  output logic [DW-1:0]         head
);

  logic [DW-1:0]         mem_q [RD_FIFO_DEPTH];
  logic [RD_FIFO_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [RD_FIFO_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [RD_FIFO_CW-1:0] count_q, count_d;

  function automatic logic [RD_FIFO_PW-1:0] ptr_inc(input logic [RD_FIFO_PW-1:0] p);
    return (p == RD_FIFO_PW'(RD_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + RD_FIFO_CW'(push) - RD_FIFO_CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only observed once
  // count says it was written, so clearing it would just cost reset fanout.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a contiguous, wrapping run of coefficients out of one BRAM bank.
// Define BRAM_STREAM_READER_BITREV_EN for bit-reversed (NTT unload) addressing.
module bram_stream_reader
  import pe4_pkg::*;
#(
  parameter int DW = PE4_DW,
  parameter int AW = PE4_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] bram_dout,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready
);

  rd_state_e             state_q, state_d;
  logic [AW-1:0]         base_q, base_d;
  logic [AW-1:0]         raddr_q, raddr_d;
  logic [AW:0]           len_q, len_d;
  logic [AW:0]           issue_cnt_q, issue_cnt_d;
  logic [AW:0]           beat_cnt_q, beat_cnt_d;
  logic                  rd_pending_q, rd_pending_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [RD_FIFO_CW-1:0] fifo_count;
  logic [RD_FIFO_CW:0]   slots_used;
  logic [DW-1:0]         fifo_head;
  logic                  issue;
  logic                  pop;
  logic                  beat_last;

  function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] a);
`ifdef BRAM_STREAM_READER_BITREV_EN
    logic [AW-1:0] r;
    for (int k = 0; k < AW; k++) begin
      r[k] = a[AW-1-k];
    end
    return r;
`else
    return a;
`endif
  endfunction

  // raddr is presented a cycle ahead; the BRAM read that counts happens on
  // the issuing edge, so only one read is ever in flight toward the FIFO.
  assign slots_used = {1'b0, fifo_count} + (RD_FIFO_CW + 1)'(rd_pending_q);
  assign issue      = (state_q == READ) && (slots_used < (RD_FIFO_CW + 1)'(RD_FIFO_DEPTH));
  assign m_valid    = (fifo_count != '0);
  assign pop        = m_valid && m_ready;
  assign beat_last  = (beat_cnt_q == len_q - (AW + 1)'(1));

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    issue_cnt_d  = issue_cnt_q;
    beat_cnt_d   = pop ? beat_cnt_q + (AW + 1)'(1) : beat_cnt_q;
    raddr_d      = raddr_q;
    rd_pending_d = issue;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = READ;
            base_d      = base;
            len_d       = len;
            issue_cnt_d = '0;
            beat_cnt_d  = '0;
            raddr_d     = map_addr(base);
            busy_d      = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + (AW + 1)'(1);
          raddr_d     = map_addr(base_q + issue_cnt_d[AW-1:0]);
          if (issue_cnt_d == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && beat_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      issue_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      raddr_q      <= '0;
      rd_pending_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      issue_cnt_q  <= issue_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      raddr_q      <= raddr_d;
      rd_pending_q <= rd_pending_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  rd_skid_fifo #(
    .DW(DW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_pending_q),
    .push_data(bram_dout),
    .pop      (pop),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign raddr  = raddr_q;
  assign m_data = m_valid ? fifo_head : '0;
  assign m_last = m_valid && beat_last;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised self-checking bench for bram_stream_reader against a queue-based
// reference of the expected coefficient sequence and stream timing.
module tb_bram_stream_reader;

  localparam int DW    = 12;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr;
  logic [DW-1:0] bram_dout;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  logic [DW-1:0] mem [DEPTH];
  int            n_checks = 0;
  int            n_fail   = 0;

  bram_stream_reader #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .raddr    (raddr),
    .bram_dout(bram_dout),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read bank: data for raddr appears one cycle after it is presented.
  always @(posedge clk) bram_dout <= mem[raddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_addr(input int b, input int i);
    int a;
    int r;
    a = (b + i) % DEPTH;
    r = a;
`ifdef BRAM_STREAM_READER_BITREV_EN
    r = 0;
    for (int k = 0; k < AW; k++) begin
      if (((a >> k) & 1) != 0) r = r | (1 << (AW - 1 - k));
    end
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high (strict timing checked), 1: alternating, 2: random.
  // restart_at >= 0 pulses a competing start in that cycle, which must be ignored.
  task automatic run_transfer(input int b, input int n, input int mode, input int restart_at);
    int            exp_q[$];
    int            cyc;
    int            accepted;
    int            issued;
    int            budget;
    logic [AW-1:0] prev_raddr;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    bit            stalled;

    for (int i = 0; i < n; i++) exp_q.push_back(ref_addr(b, i) + 100);
    base    = AW'(b);
    len     = (AW + 1)'(n);
    start   = 1'b1;
    m_ready = (mode == 0);
    step();
    start      = 1'b0;
    cyc        = 1;
    accepted   = 0;
    issued     = 0;
    stalled    = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    prev_raddr = raddr;
    budget     = 40 * n + 50;
    check("first_raddr", raddr, ref_addr(b, 0));

    while (accepted < n && cyc < budget) begin
      start = (cyc == restart_at);
      if (start) begin
        base = AW'(b + 7);
        len  = (AW + 1)'(5);
      end
      if (cyc > 1 && raddr != prev_raddr) issued++;
      prev_raddr = raddr;
      check("outstanding_le3", (issued - accepted) <= 3, 1'b1);
      check("busy_during", busy, 1'b1);
      if (stalled) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      if (mode == 0) begin
        check("valid_timing", m_valid, cyc >= 3);
        if (cyc <= n) check("raddr_seq", raddr, ref_addr(b, cyc - 1));
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2 == 1);
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (m_valid && m_ready) begin
        check("beat_data", m_data, exp_q.pop_front());
        check("beat_last", m_last, accepted == n - 1);
        accepted++;
      end
      stalled   = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      step();
      cyc++;
    end

    start   = 1'b0;
    m_ready = 1'b0;
    check("no_timeout", accepted, n);
    check("done_pulse", done, 1'b1);
    check("busy_clear", busy, 1'b0);
    check("valid_clear", m_valid, 1'b0);
    check("issued_total", issued, n);
    step();
    check("done_single", done, 1'b0);
    check("no_extra_beat", m_valid, 1'b0);
  endtask

  initial begin
    int cnt;
    int guard;

    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a + 100);
    rst_n   = 1'b0;
    start   = 1'b0;
    base    = '0;
    len     = '0;
    m_ready = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", m_valid, 1'b0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 1'b0);
    check("rst_raddr", raddr, 0);
    rst_n = 1'b1;
    step();

    // Full bank, then a wrapping run, then stalls.
    run_transfer(0, 64, 0, -1);
    run_transfer(60, 8, 0, -1);
    run_transfer(0, 16, 1, -1);

    // Zero-length request completes immediately with no beats.
    base  = AW'(5);
    len   = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("len0_done", done, 1'b1);
    check("len0_busy", busy, 1'b0);
    check("len0_valid", m_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("len0_quiet", {m_valid, done, busy}, 0);
    end

    // A start pulse while busy must not disturb the running transfer.
    run_transfer(10, 8, 0, 4);

    // Reset in the middle of a 20-beat transfer.
    base    = '0;
    len     = (AW + 1)'(20);
    m_ready = 1'b1;
    start   = 1'b1;
    step();
    start = 1'b0;
    cnt   = 0;
    guard = 0;
    while (cnt < 5 && guard < 100) begin
      if (m_valid && m_ready) cnt++;
      step();
      guard++;
    end
    check("rst_pre_beats", cnt, 5);
    rst_n = 1'b0;
    step();
    check("midrst_valid", m_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_raddr", raddr, 0);
    check("midrst_data", m_data, 0);
    check("midrst_last", m_last, 1'b0);
    check("midrst_done", done, 1'b0);
    rst_n   = 1'b1;
    m_ready = 1'b0;
    step();
    run_transfer(0, 4, 0, -1);

    // Random placements, lengths and backpressure.
    for (int t = 0; t < 12; t++) begin
      run_transfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 2, -1);
    end
    run_transfer(63, 1, 2, -1);
    run_transfer(33, 64, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
